crypto_bus_fabric: RTL and testbench

Parametrised shared-bus interconnect linking N crypto blocks (control, SHA, AES, …) over one registered data bus. It replaces per-block tri-state bus taps with a central round-robin arbiter. Each transfer carries a destination ID, is delivered to exactly one receiver, and completes on that receiver's ack or on a timeout. Sits between the top-level wrapper and the crypto cores; the control port is port N_PORTS-1.

---
 rtl/crypto_bus_fabric_pkg.sv | 20 ++
 rtl/crypto_bus_fabric_rr_arbiter.sv | 33 +++
 rtl/crypto_bus_fabric.sv | 132 +++++++++++++
 tb/tb_crypto_bus_fabric.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/crypto_bus_fabric_pkg.sv
// Shared definitions for the crypto bus fabric: FSM state encoding, fixed port IDs
// and the ID-width helper used to size the bus fields.
package crypto_bus_fabric_pkg;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_DELIVER = 1'b1
  } bus_state_e;

  localparam int ID_SHA = 1;

  // Ceiling log2, never below 1 so every derived field has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/crypto_bus_fabric_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after
// last_grant, wrapping around the port list.
module rr_arbiter
  import crypto_bus_fabric_pkg::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic [N-1:0]    gnt_onehot,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  assign any = |req;

  // Walk from the farthest candidate to the nearest so the closest requester overrides.
  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    for (int i = N; i >= 1; i--) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((int'(last_grant) + i) % N);
      if (req[idx]) begin
        gnt_onehot      = '0;
        gnt_onehot[idx] = 1'b1;
        gnt_id          = idx;
      end
    end
  end

endmodule

// File: rtl/crypto_bus_fabric.sv
// Shared registered bus between N crypto blocks: round-robin grant, single-receiver
// delivery, completion on receiver ack or on timeout.
module crypto_bus_fabric
  import crypto_bus_fabric_pkg::*;
#(
  parameter  int N_PORTS     = 4,
  parameter  int DATA_W      = 8,
  parameter  int ACK_TIMEOUT = 15,
  localparam int ID_W        = clog2(N_PORTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        send_valid,
  input  logic [N_PORTS*DATA_W-1:0] send_data,
  input  logic [N_PORTS*ID_W-1:0]   send_dest,
  output logic [N_PORTS-1:0]        send_ready,
  output logic [N_PORTS-1:0]        send_err,
  output logic [N_PORTS-1:0]        recv_valid,
  output logic [DATA_W-1:0]         recv_data,
  output logic [ID_W-1:0]           recv_src,
  input  logic [N_PORTS-1:0]        recv_ack,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  localparam int ID_CTRL = N_PORTS - 1;
  localparam int TMR_W   = clog2(ACK_TIMEOUT + 1);

  bus_state_e          state_q;
  logic [ID_W-1:0]     last_grant_q;
  logic [ID_W-1:0]     src_q;
  logic [DATA_W-1:0]   data_q;
  logic [N_PORTS-1:0]  recv_valid_q;
  logic [N_PORTS-1:0]  send_ready_q;
  logic [N_PORTS-1:0]  send_err_q;
  logic                busy_q;
  logic [ID_W-1:0]     grant_id_q;
  logic [TMR_W-1:0]    timer_q;

  logic [N_PORTS-1:0]  arb_onehot;
  logic [ID_W-1:0]     arb_id;
  logic                arb_any;
  logic [DATA_W-1:0]   sel_data;
  logic [ID_W-1:0]     sel_dest;
  logic                dest_bad;
  logic                ack_hit;
  logic                expired;
  logic [N_PORTS-1:0]  src_onehot;

  rr_arbiter #(.N(N_PORTS)) u_arb (
    .req        (send_valid),
    .last_grant (last_grant_q),
    .gnt_onehot (arb_onehot),
    .gnt_id     (arb_id),
    .any        (arb_any)
  );

  always_comb begin
    sel_data = '0;
    sel_dest = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (arb_onehot[i]) begin
        sel_data = send_data[i*DATA_W +: DATA_W];
        sel_dest = send_dest[i*ID_W +: ID_W];
      end
    end
  end

  assign dest_bad   = (sel_dest == arb_id) || (32'(sel_dest) >= 32'(N_PORTS));
  // recv_valid_q holds exactly the destination bit, so masking filters foreign acks.
  assign ack_hit    = |(recv_ack & recv_valid_q);
  assign expired    = (ACK_TIMEOUT != 0) && (timer_q == TMR_W'(ACK_TIMEOUT - 1));
  assign src_onehot = N_PORTS'(1) << src_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(ID_CTRL);
      src_q        <= '0;
      data_q       <= '0;
      recv_valid_q <= '0;
      send_ready_q <= '0;
      send_err_q   <= '0;
      busy_q       <= 1'b0;
      grant_id_q   <= '0;
      timer_q      <= '0;
    end else begin
      send_ready_q <= '0;
      send_err_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (arb_any) begin
            last_grant_q <= arb_id;
            grant_id_q   <= arb_id;
            src_q        <= arb_id;
            data_q       <= sel_data;
            timer_q      <= '0;
            if (dest_bad) begin
              send_err_q <= arb_onehot;
            end else begin
              recv_valid_q <= N_PORTS'(1) << sel_dest;
              busy_q       <= 1'b1;
              state_q      <= S_DELIVER;
            end
          end
        end
        S_DELIVER: begin
          // Ack is checked first so it wins over a timeout expiring in the same cycle.
          if (ack_hit || expired) begin
            recv_valid_q <= '0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
            if (ack_hit) send_ready_q <= src_onehot;
            else         send_err_q   <= src_onehot;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign send_ready = send_ready_q;
  assign send_err   = send_err_q;
  assign recv_valid = recv_valid_q;
  assign recv_data  = data_q;
  assign recv_src   = src_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_crypto_bus_fabric.sv
// Directed bench for crypto_bus_fabric (4 ports, 8-bit data, timeout 15).
module tb_crypto_bus_fabric;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  send_valid = '0;
  logic [31:0] send_data  = '0;
  logic [7:0]  send_dest  = '0;
  logic [3:0]  send_ready;
  logic [3:0]  send_err;
  logic [3:0]  recv_valid;
  logic [7:0]  recv_data;
  logic [1:0]  recv_src;
  logic [3:0]  recv_ack   = '0;
  logic        busy;
  logic [1:0]  grant_id;

  int errors = 0;
  int checks = 0;
  int hi;

  crypto_bus_fabric #(.N_PORTS(4), .DATA_W(8), .ACK_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .send_valid (send_valid),
    .send_data  (send_data),
    .send_dest  (send_dest),
    .send_ready (send_ready),
    .send_err   (send_err),
    .recv_valid (recv_valid),
    .recv_data  (recv_data),
    .recv_src   (recv_src),
    .recv_ack   (recv_ack),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [7:0] d, input logic [1:0] dst);
    send_valid[p]       = 1'b1;
    send_data[p*8 +: 8] = d;
    send_dest[p*2 +: 2] = dst;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_recv_valid"}, 32'(recv_valid), 0);
    check({tag, "_recv_data"},  32'(recv_data),  0);
    check({tag, "_recv_src"},   32'(recv_src),   0);
    check({tag, "_busy"},       32'(busy),       0);
    check({tag, "_grant_id"},   32'(grant_id),   0);
    check({tag, "_send_ready"}, 32'(send_ready), 0);
    check({tag, "_send_err"},   32'(send_err),   0);
  endtask

  initial begin
    int exp_src [6];
    logic [7:0] exp_dat [4];
    exp_src = '{0, 1, 3, 0, 1, 3};
    exp_dat = '{8'h10, 8'h21, 8'h00, 8'h43};

    #2;
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // Single transfer: port 1 -> port 0, acked on first recv_valid cycle
    send(1, 8'hA5, 2'd0);
    recv_ack[0] = 1'b1;
    tick();
    check("single_recv_valid", 32'(recv_valid), 32'h1);
    check("single_recv_data",  32'(recv_data),  32'hA5);
    check("single_recv_src",   32'(recv_src),   1);
    check("single_busy",       32'(busy),       1);
    check("single_grant_id",   32'(grant_id),   1);
    check("single_ready_early", 32'(send_ready), 0);
    tick();
    check("single_send_ready", 32'(send_ready), 32'h2);
    check("single_recv_drop",  32'(recv_valid), 0);
    check("single_busy_drop",  32'(busy),       0);
    send_valid  = '0;
    recv_ack    = '0;
    tick();
    check("single_ready_pulse", 32'(send_ready), 0);

    // Round robin from reset: ports 0,1,3 to dest 2, auto-ack
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(0, 8'h10, 2'd2);
    send(1, 8'h21, 2'd2);
    send(3, 8'h43, 2'd2);
    recv_ack[2] = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      check($sformatf("rr%0d_recv_valid", t), 32'(recv_valid), 32'h4);
      check($sformatf("rr%0d_src", t),        32'(recv_src),   32'(exp_src[t]));
      check($sformatf("rr%0d_grant", t),      32'(grant_id),   32'(exp_src[t]));
      check($sformatf("rr%0d_data", t),       32'(recv_data),  32'(exp_dat[exp_src[t]]));
      tick();
      check($sformatf("rr%0d_ready", t),      32'(send_ready), 32'(1 << exp_src[t]));
    end
    send_valid = '0;
    recv_ack   = '0;
    tick();

    // Invalid destination: port 2 to itself
    send(2, 8'h77, 2'd2);
    tick();
    check("inv_send_err",    32'(send_err),   32'h4);
    check("inv_recv_valid",  32'(recv_valid), 0);
    check("inv_busy",        32'(busy),       0);
    check("inv_send_ready",  32'(send_ready), 0);
    send_valid = '0;
    tick();
    check("inv_err_pulse",   32'(send_err),   0);

    // Timeout without ack
    send(1, 8'h3C, 2'd0);
    tick();
    hi = 0;
    for (int n = 0; n < 20 && recv_valid != 4'b0; n++) begin
      hi++;
      tick();
    end
    check("to_high_cycles", 32'(hi),         15);
    check("to_send_err",    32'(send_err),   32'h2);
    check("to_send_ready",  32'(send_ready), 0);
    check("to_busy",        32'(busy),       0);
    send_valid = '0;

    // Ack on the 15th recv_valid cycle wins over the timeout
    send(1, 8'h5A, 2'd0);
    tick();
    for (int n = 0; n < 14; n++) tick();
    check("late_still_valid", 32'(recv_valid), 32'h1);
    recv_ack[0] = 1'b1;
    tick();
    check("late_send_ready", 32'(send_ready), 32'h2);
    check("late_send_err",   32'(send_err),   0);
    check("late_recv_drop",  32'(recv_valid), 0);
    send_valid = '0;
    recv_ack   = '0;
    tick();

    // Wrong-port ack is ignored, then reset mid-delivery
    send(0, 8'hC3, 2'd3);
    recv_ack[0] = 1'b1;
    tick();
    check("wp_recv_valid", 32'(recv_valid), 32'h8);
    for (int n = 0; n < 3; n++) tick();
    check("wp_still_valid", 32'(recv_valid), 32'h8);
    check("wp_no_ready",    32'(send_ready), 0);
    check("wp_busy",        32'(busy),       1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    send_valid = '0;
    recv_ack   = '0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(send_ready), 0);
    check("post_rst_err",   32'(send_err),   0);
    check("post_rst_valid", 32'(recv_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
